q_frag_ctrl_seq: RTL and testbench

- Command sequencer directly upstream of a bank of LANES Q_FRAG flip-flops.
- Drives their QDI/QEN/CDS/QST/QRT pins and reads their AQZ outputs back.
- Turns valid/ready commands (WRITE, CLEAR, PRESET, READ) into correctly timed per-lane pin activity.
- Guarantees one quiet recovery cycle after any async set/reset pulse, because the flops ignore QCK while set/reset is asserted.

---
 rtl/q_frag_ctrl_seq.sv | 153 +++++++++++++++
 tb/tb_q_frag_ctrl_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/q_frag_ctrl_seq.sv
// Purpose: sequences WRITE/CLEAR/PRESET/READ commands onto a bank of Q_FRAG flops, with a quiet recovery cycle after set/reset pulses.
// Latency: WRITE 1 cycle, CLEAR/PRESET CLR_CYCLES+1 cycles, READ response registered 2 cycles after accept.
// Backpressure: CMD_READY only in IDLE; a READ response is held in RESP until RSP_READY, blocking new commands.
module q_frag_ctrl_seq #(
    parameter int LANES      = 8,
    parameter int CLR_CYCLES = 2
) (
    input  logic             QCK,
    input  logic             QRT,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [LANES-1:0] CMD_DATA,
    input  logic [LANES-1:0] CMD_MASK,
    output logic [LANES-1:0] L_QDI,
    output logic [LANES-1:0] L_QEN,
    output logic             L_CDS,
    output logic [LANES-1:0] L_QST,
    output logic [LANES-1:0] L_QRT,
    input  logic [LANES-1:0] L_AQZ,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [LANES-1:0] RSP_DATA,
    output logic             BUSY
);

    localparam int CLR_N = (CLR_CYCLES < 1) ? 1 : CLR_CYCLES;
    localparam int CW    = $clog2(CLR_N + 1);

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_PRE = 2'b10;

    typedef struct packed {
        logic [1:0]       op;
        logic [LANES-1:0] dat;
        logic [LANES-1:0] mask;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_PULSE,
        S_RECOVER,
        S_SETTLE,
        S_RESP
    } state_t;

    state_t           state, state_nxt;
    cmd_t             cmd_q, cmd_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic [LANES-1:0] qdi_nxt, qen_nxt, qst_nxt, qrt_nxt, rsp_dat_nxt;
    logic             cds_nxt, rsp_vld_nxt, busy_nxt;
    logic             accept;

    assign CMD_READY = (state == S_IDLE) && !QRT;
    assign accept    = CMD_VALID && CMD_READY;

    always_comb begin
        state_nxt   = state;
        cmd_nxt     = cmd_q;
        cnt_nxt     = cnt_q;
        qdi_nxt     = '0;
        qen_nxt     = '0;
        cds_nxt     = 1'b0;
        qst_nxt     = '0;
        qrt_nxt     = '0;
        rsp_vld_nxt = RSP_VALID;
        rsp_dat_nxt = RSP_DATA;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    cmd_nxt = '{op: CMD_OP, dat: CMD_DATA, mask: CMD_MASK};
                    case (CMD_OP)
                        OP_WR: begin
                            state_nxt = S_WRITE;
                            qdi_nxt   = CMD_DATA;
                            qen_nxt   = CMD_MASK;
                            cds_nxt   = 1'b1;
                        end
                        OP_CLR: begin
                            state_nxt = S_PULSE;
                            cnt_nxt   = CW'(CLR_N);
                            qrt_nxt   = CMD_MASK;
                        end
                        OP_PRE: begin
                            state_nxt = S_PULSE;
                            cnt_nxt   = CW'(CLR_N);
                            qst_nxt   = CMD_MASK;
                        end
                        default: state_nxt = S_SETTLE;
                    endcase
                end
            end
            S_WRITE: state_nxt = S_IDLE;
            S_PULSE: begin
                // The counter holds the pulse cycles remaining including this one.
                if (cnt_q <= CW'(1)) begin
                    state_nxt = S_RECOVER;
                end else begin
                    cnt_nxt = cnt_q - CW'(1);
                    if (cmd_q.op == OP_CLR) qrt_nxt = cmd_q.mask;
                    else                    qst_nxt = cmd_q.mask;
                end
            end
            S_RECOVER: state_nxt = S_IDLE;
            S_SETTLE: begin
                state_nxt   = S_RESP;
                rsp_vld_nxt = 1'b1;
                rsp_dat_nxt = L_AQZ & cmd_q.mask;
            end
            S_RESP: begin
                if (RSP_READY) begin
                    state_nxt   = S_IDLE;
                    rsp_vld_nxt = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            cnt_q     <= '0;
            L_QDI     <= '0;
            L_QEN     <= '0;
            L_CDS     <= 1'b0;
            L_QST     <= '0;
            L_QRT     <= '0;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            BUSY      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_q     <= cmd_nxt;
            cnt_q     <= cnt_nxt;
            L_QDI     <= qdi_nxt;
            L_QEN     <= qen_nxt;
            L_CDS     <= cds_nxt;
            L_QST     <= qst_nxt;
            L_QRT     <= qrt_nxt;
            RSP_VALID <= rsp_vld_nxt;
            RSP_DATA  <= rsp_dat_nxt;
            BUSY      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_q_frag_ctrl_seq.sv
// Directed bench for q_frag_ctrl_seq driving a behavioural bank of 8 Q_FRAG flops.
module tb_q_frag_ctrl_seq;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_PRE = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;

    logic       QCK, QRT, CMD_VALID, CMD_READY, L_CDS, RSP_VALID, RSP_READY, BUSY;
    logic [1:0] CMD_OP;
    logic [7:0] CMD_DATA, CMD_MASK, L_QDI, L_QEN, L_QST, L_QRT, L_AQZ, RSP_DATA;
    logic [7:0] flop_q;

    int checks = 0;
    int errors = 0;

    q_frag_ctrl_seq #(.LANES(8), .CLR_CYCLES(2)) dut (
        .QCK(QCK), .QRT(QRT),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
        .CMD_DATA(CMD_DATA), .CMD_MASK(CMD_MASK),
        .L_QDI(L_QDI), .L_QEN(L_QEN), .L_CDS(L_CDS), .L_QST(L_QST), .L_QRT(L_QRT),
        .L_AQZ(L_AQZ),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .BUSY(BUSY)
    );

    initial QCK = 1'b0;
    always #5 QCK = ~QCK;

    // Flop bank: async set/reset dominate, otherwise capture QDI where QEN and CDS.
    initial flop_q = 8'h00;
    always @(posedge QCK)
        flop_q <= (((flop_q & ~(L_QEN & {8{L_CDS}})) | (L_QDI & L_QEN & {8{L_CDS}})) | L_QST) & ~L_QRT;
    assign L_AQZ = (flop_q | L_QST) & ~L_QRT;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d, input logic [7:0] m);
        int n;
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_DATA  = d;
        CMD_MASK  = m;
        n = 0;
        while (!CMD_READY && n < 20) begin
            @(negedge QCK);
            n++;
        end
        if (!CMD_READY) check("send_timeout", 32'd0, 32'd1);
        @(negedge QCK);
        CMD_VALID = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [7:0] d, input logic [7:0] m);
        send(OP_WR, d, m);
        check({tag, "_cds"}, L_CDS, 1);
        check({tag, "_qen"}, L_QEN, m);
        check({tag, "_qdi"}, L_QDI, d);
        check({tag, "_busy"}, BUSY, 1);
        @(negedge QCK);
        check({tag, "_cds_off"}, L_CDS, 0);
        check({tag, "_qen_off"}, L_QEN, 0);
        check({tag, "_rdy"}, CMD_READY, 1);
    endtask

    task automatic do_read(input string tag, input logic [7:0] m, input logic [7:0] exp);
        RSP_READY = 1'b1;
        send(OP_RD, 8'h00, m);
        check({tag, "_settle_vld"}, RSP_VALID, 0);
        check({tag, "_settle_busy"}, BUSY, 1);
        @(negedge QCK);
        check({tag, "_vld"}, RSP_VALID, 1);
        check({tag, "_data"}, RSP_DATA, exp);
        @(negedge QCK);
        check({tag, "_vld_off"}, RSP_VALID, 0);
        check({tag, "_data_kept"}, RSP_DATA, exp);
        check({tag, "_rdy"}, CMD_READY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        QRT = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_DATA = 8'h00; CMD_MASK = 8'h00;
        RSP_READY = 1'b0;
        @(negedge QCK); @(negedge QCK);
        check("rst_rdy", CMD_READY, 0);
        check("rst_busy", BUSY, 0);
        check("rst_l", {L_QDI, L_QEN, L_QST, L_QRT}, 0);
        check("rst_cds", L_CDS, 0);
        check("rst_rsp", {RSP_VALID, RSP_DATA}, 0);
        QRT = 1'b0;
        #1 check("rel_rdy", CMD_READY, 1);
        @(negedge QCK);

        // Write then read back
        do_write("w1", 8'hA5, 8'hFF);
        do_read("r1", 8'hFF, 8'hA5);

        // CLEAR low nibble: 2 pulse cycles, 1 recovery cycle
        do_write("w2", 8'hFF, 8'hFF);
        send(OP_CLR, 8'h00, 8'h0F);
        check("clr_p1_qrt", L_QRT, 8'h0F);
        check("clr_p1_qst", L_QST, 0);
        check("clr_p1_rdy", CMD_READY, 0);
        @(negedge QCK);
        check("clr_p2_qrt", L_QRT, 8'h0F);
        check("clr_p2_rdy", CMD_READY, 0);
        @(negedge QCK);
        check("clr_rec_qrt", L_QRT, 0);
        check("clr_rec_rdy", CMD_READY, 0);
        check("clr_rec_busy", BUSY, 1);
        @(negedge QCK);
        check("clr_idle_rdy", CMD_READY, 1);
        check("clr_idle_busy", BUSY, 0);
        do_read("r2", 8'hFF, 8'hF0);

        // PRESET with a WRITE held behind it
        send(OP_PRE, 8'h00, 8'h81);
        check("pre_p1_qst", L_QST, 8'h81);
        check("pre_p1_qrt", L_QRT, 0);
        CMD_VALID = 1'b1; CMD_OP = OP_WR; CMD_DATA = 8'h00; CMD_MASK = 8'h01;
        @(negedge QCK);
        check("pre_p2_qst", L_QST, 8'h81);
        check("pre_p2_qen", L_QEN, 0);
        @(negedge QCK);
        check("pre_rec_qst", L_QST, 0);
        check("pre_rec_cds", L_CDS, 0);
        check("pre_rec_rdy", CMD_READY, 0);
        @(negedge QCK);
        check("pre_idle_qen", L_QEN, 0);
        check("pre_idle_rdy", CMD_READY, 1);
        @(negedge QCK);
        CMD_VALID = 1'b0;
        check("pre_w_qen", L_QEN, 8'h01);
        check("pre_w_cds", L_CDS, 1);
        @(negedge QCK);
        do_read("r3", 8'h81, 8'h80);

        // Stalled response: no new command accepted while RSP_READY is low
        RSP_READY = 1'b0;
        send(OP_RD, 8'h00, 8'hFF);
        @(negedge QCK);
        for (int i = 0; i < 5; i++) begin
            check("stall_vld", RSP_VALID, 1);
            check("stall_data", RSP_DATA, 8'hF0);
            check("stall_rdy", CMD_READY, 0);
            check("stall_qen", L_QEN, 0);
            CMD_VALID = 1'b1; CMD_OP = OP_WR; CMD_DATA = 8'hFF; CMD_MASK = 8'hFF;
            @(negedge QCK);
        end
        RSP_READY = 1'b1;
        @(negedge QCK);
        check("stall_rel_vld", RSP_VALID, 0);
        check("stall_rel_data", RSP_DATA, 8'hF0);
        check("stall_rel_rdy", CMD_READY, 1);
        @(negedge QCK);
        CMD_VALID = 1'b0;
        check("stall_w_cds", L_CDS, 1);
        check("stall_w_qen", L_QEN, 8'hFF);
        @(negedge QCK);

        // Reset during second CLEAR pulse cycle
        send(OP_CLR, 8'h00, 8'h0F);
        check("arst_p1_qrt", L_QRT, 8'h0F);
        @(negedge QCK);
        check("arst_p2_qrt", L_QRT, 8'h0F);
        #1 QRT = 1'b1;
        #1;
        check("arst_qrt", L_QRT, 0);
        check("arst_busy", BUSY, 0);
        check("arst_rdy", CMD_READY, 0);
        @(negedge QCK);
        check("arst_hold_rdy", CMD_READY, 0);
        QRT = 1'b0;
        #1 check("arst_rel_rdy", CMD_READY, 1);
        @(negedge QCK);

        // Back-to-back WRITEs with empty mask
        CMD_VALID = 1'b1; CMD_OP = OP_WR; CMD_DATA = 8'hFF; CMD_MASK = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            @(negedge QCK);
            check("b2b_cds", L_CDS, (k % 2 == 1) ? 1 : 0);
            check("b2b_qen", L_QEN, 0);
        end
        CMD_VALID = 1'b0;
        @(negedge QCK);
        do_read("r4", 8'hFF, 8'hF0);
        do_read("r5_mask0", 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
